mc_fetch_mem_unit: RTL and testbench

Memory-side datapath stage driven by the multicycle control unit. Holds the PC, the unified instruction/data memory, the Instruction Register (IR) and the Memory Data Register (MDR). Consumes the control unit's IorD/MemRead/MemWrite/IRWrite/PCWrite_F/PCSource strobes and returns the decoded instruction fields, including `opcode`, which feeds back into the control unit.

---
 rtl/mc_pkg.sv | 28 ++
 rtl/mc_word_mem.sv | 37 +++
 rtl/mc_fetch_mem_unit.sv | 136 +++++++++++++
 tb/tb_mc_fetch_mem_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared constants for the multicycle fetch/memory datapath:
//               opcode map, PCSource encodings and datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [5:0] OP_LW    = 6'd0;
  localparam logic [5:0] OP_SW    = 6'd1;
  localparam logic [5:0] OP_RTYPE = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd3;
  localparam logic [5:0] OP_J     = 6'd4;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_HOLD   = 2'd3
  } pcsrc_e;

endpackage

`default_nettype wire

// File: rtl/mc_word_mem.sv
// ============================================================================
// Module      : mc_word_mem
// Description : Unified word memory, combinational read, synchronous write.
//               Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_word_mem
  import mc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int MEM_WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  // Read-before-write: a same-cycle write only becomes visible next cycle.
  assign rdata = mem_q[index];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[index] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mc_fetch_mem_unit.sv
// ============================================================================
// Module      : mc_fetch_mem_unit
// Description : PC, IR, MDR and unified memory for the multicycle datapath.
//               Optional misaligned-access detection via MC_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_fetch_mem_unit
  import mc_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                MEM_WORDS = 256,
  parameter logic [DATA_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IorD,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IRWrite,
  input  logic              PCWrite_F,
  input  logic [1:0]        PCSource,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic              align_err
);

  localparam int ADDR_W = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] jump_target;
  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic              mem_we;
  logic              unused_addr_bits;

  assign addr        = IorD ? alu_out : pc_q;
  assign word_idx    = addr[ADDR_W+1:2];
  assign jump_target = {pc_q[DATA_W-1 -: 4], ir_q[25:0], 2'b00};
  assign mem_we      = MemWrite & ~misaligned & ~reset;

  mc_word_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .index (word_idx),
    .wdata (wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mdr_d = mdr_q;
    if (IRWrite) begin
      ir_d = mem_rdata;
    end
    // MDR must hold through MEM_WB, and a fetch never disturbs it.
    if (MemRead && !IRWrite) begin
      mdr_d = mem_rdata;
    end
    if (PCWrite_F) begin
      case (PCSource)
        PCSRC_ALU:    pc_d = alu_result;
        PCSRC_ALUOUT: pc_d = alu_out;
        PCSRC_JUMP:   pc_d = jump_target;
        default:      pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      mdr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mdr_q <= mdr_d;
    end
  end

`ifdef MC_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;

  assign misaligned = (addr[1:0] != 2'b00);

  always_comb begin
    align_err_d = align_err_q | (misaligned & (MemRead | MemWrite | IRWrite));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= align_err_d;
    end
  end

  assign align_err        = align_err_q;
  assign unused_addr_bits = ^addr[DATA_W-1:ADDR_W+2];
`else
  assign misaligned       = 1'b0;
  assign align_err        = 1'b0;
  assign unused_addr_bits = ^{addr[DATA_W-1:ADDR_W+2], addr[1:0]};
`endif

  assign pc     = pc_q;
  assign ir     = ir_q;
  assign mdr    = mdr_q;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign imm    = ir_q[15:0];

endmodule

`default_nettype wire

// File: tb/tb_mc_fetch_mem_unit.sv
// ============================================================================
// Module      : tb_mc_fetch_mem_unit
// Description : Self-checking bench for mc_fetch_mem_unit against a
//               behavioural model (honours MC_ALIGN_CHECK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_fetch_mem_unit;

  localparam int          MW  = 256;
  localparam logic [31:0] RPC = 32'h40;

  logic        clk = 1'b0;
  logic        reset;
  logic        IorD, MemRead, MemWrite, IRWrite, PCWrite_F;
  logic [1:0]  PCSource;
  logic [31:0] alu_result, alu_out, wdata;
  logic [31:0] pc, ir, mdr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        align_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [MW];
  logic [31:0] pc_m, ir_m, mdr_m;
  logic        err_m;
  bit          align_on;

  mc_fetch_mem_unit #(.DATA_W(32), .MEM_WORDS(MW), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite_F(PCWrite_F), .PCSource(PCSource),
    .alu_result(alu_result), .alu_out(alu_out), .wdata(wdata),
    .pc(pc), .ir(ir), .mdr(mdr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .align_err(align_err)
  );

  always #5 clk = ~clk;

  // One clock of the datapath: drive inputs, advance the model, sample at edge+1.
  task automatic step(input logic iord, input logic mr, input logic mw, input logic irw,
                      input logic pcw, input logic [1:0] src, input logic [31:0] ares,
                      input logic [31:0] aout, input logic [31:0] wd);
    logic [31:0] a, rdat, npc;
    int          idx;
    bit          mis;
    IorD = iord; MemRead = mr; MemWrite = mw; IRWrite = irw; PCWrite_F = pcw;
    PCSource = src; alu_result = ares; alu_out = aout; wdata = wd;
    a    = iord ? aout : pc_m;
    idx  = int'(a / 4) % MW;
    rdat = mem_m[idx];
    mis  = align_on && (a % 4 != 0);
    npc  = pc_m;
    if (pcw) begin
      if (src == 2'd0) npc = ares;
      else if (src == 2'd1) npc = aout;
      else if (src == 2'd2) npc = (pc_m & 32'hF000_0000) | ((ir_m & 32'h03FF_FFFF) * 4);
    end
    if (mis && (mr || mw || irw)) err_m = 1'b1;
    if (mw && !mis) mem_m[idx] = wd;
    if (mr && !irw) mdr_m = rdat;
    if (irw) ir_m = rdat;
    pc_m = npc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc_m = RPC; ir_m = '0; mdr_m = '0; err_m = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < MW; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'h0, 32'(i * 4), $urandom);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 0, 32'h4, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h1230, 32'h8, 0);
    // Assert reset mid-cycle with a write strobe pending.
    MemWrite = 1'b1; IorD = 1'b1; alu_out = 32'h8; wdata = 32'hDEAD_BEEF;
    #1;
    reset = 1'b1;
    #1;
    checks++; if (pc !== RPC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RPC); end
    checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want 0", ir); end
    checks++; if (mdr !== 32'h0) begin errors++; $display("FAIL reset_mdr: got %h want 0", mdr); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", align_err); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc_m = RPC; ir_m = '0; mdr_m = '0; err_m = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 0, 32'h8, 0);
    checks++; if (mdr !== mem_m[2]) begin errors++; $display("FAIL reset_nowrite: got %h want %h", mdr, mem_m[2]); end
  endtask

  task automatic test_fetch();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h0822_1800);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h4, 32'h0, 0);
    checks++; if (ir !== 32'h0822_1800) begin errors++; $display("FAIL fetch_ir: got %h want 08221800", ir); end
    checks++; if (opcode !== 6'd2) begin errors++; $display("FAIL fetch_opcode: got %0d want 2", opcode); end
    checks++; if ({rs, rt, rd} !== {5'd1, 5'd2, 5'd3}) begin
      errors++; $display("FAIL fetch_regs: got %0d/%0d/%0d want 1/2/3", rs, rt, rd); end
    checks++; if (imm !== 16'h1800) begin errors++; $display("FAIL fetch_imm: got %h want 1800", imm); end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL fetch_pc: got %h want 4", pc); end
  endtask

  task automatic test_mdr_hold();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 0, 32'h14, 32'hCAFE_F00D);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 0, 32'h14, 0);
    checks++; if (mdr !== 32'hCAFE_F00D) begin errors++; $display("FAIL mdr_load: got %h want cafef00d", mdr); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 0, 32'h18, 0);
    checks++; if (mdr !== 32'hCAFE_F00D) begin errors++; $display("FAIL mdr_hold: got %h want cafef00d", mdr); end
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 0, 32'h18, 0);
    checks++; if (mdr !== 32'hCAFE_F00D) begin errors++; $display("FAIL mdr_irwrite: got %h want cafef00d", mdr); end
    checks++; if (ir !== mem_m[6]) begin errors++; $display("FAIL ir_load: got %h want %h", ir, mem_m[6]); end
  endtask

  task automatic test_write_wrap();
    logic [31:0] old;
    old = mem_m[255];
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 0, 32'h3FC, 32'h1234_5678);
    checks++; if (mdr !== old) begin errors++; $display("FAIL rdw_old: got %h want %h", mdr, old); end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 0, 32'h1000_03FC, 0);
    checks++; if (mdr !== 32'h1234_5678) begin errors++; $display("FAIL wrap_new: got %h want 12345678", mdr); end
  endtask

  task automatic test_jump();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 0, 32'h80, 32'h1000_0010);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 0, 32'h80, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 0, 32'hA000_0008, 0);
    checks++; if (pc !== 32'hA000_0008) begin errors++; $display("FAIL pc_aluout: got %h want a0000008", pc); end
    checks++; if (opcode !== 6'd4) begin errors++; $display("FAIL j_opcode: got %0d want 4", opcode); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 0, 0, 0);
    checks++; if (pc !== 32'hA000_0040) begin errors++; $display("FAIL pc_jump: got %h want a0000040", pc); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'h4, 32'h8, 0);
    checks++; if (pc !== 32'hA000_0040) begin errors++; $display("FAIL pc_hold3: got %h want a0000040", pc); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h4, 32'h8, 0);
    checks++; if (pc !== 32'hA000_0040) begin errors++; $display("FAIL pc_nowrite: got %h want a0000040", pc); end
  endtask

  task automatic test_align();
    logic [31:0] old;
    old = mem_m[8];
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 0, 32'h22, 32'h5A5A_5A5A);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 0, 32'h20, 0);
    if (align_on) begin
      checks++; if (mdr !== old) begin errors++; $display("FAIL align_suppress: got %h want %h", mdr, old); end
      checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_set: got %b want 1", align_err); end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 0, 0, 0);
      checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_sticky: got %b want 1", align_err); end
      do_reset();
      checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_clear: got %b want 0", align_err); end
    end else begin
      checks++; if (mdr !== 32'h5A5A_5A5A) begin errors++; $display("FAIL align_trunc: got %h want 5a5a5a5a", mdr); end
      checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_tied: got %b want 0", align_err); end
    end
  endtask

  task automatic test_random();
    logic [31:0] aout, ares;
    for (int n = 0; n < 300; n++) begin
      aout = $urandom;
      ares = $urandom;
      if ($urandom_range(15) != 0) aout[1:0] = 2'b00;
      if ($urandom_range(15) != 0) ares[1:0] = 2'b00;
      step(1'($urandom), 1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0),
           1'($urandom_range(3) == 0), 1'($urandom), 2'($urandom), ares, aout, $urandom);
      checks++; if (pc !== pc_m) begin errors++; $display("FAIL rnd_pc: got %h want %h", pc, pc_m); end
      checks++; if (ir !== ir_m) begin errors++; $display("FAIL rnd_ir: got %h want %h", ir, ir_m); end
      checks++; if (mdr !== mdr_m) begin errors++; $display("FAIL rnd_mdr: got %h want %h", mdr, mdr_m); end
      checks++; if (opcode !== ir_m[31:26]) begin errors++; $display("FAIL rnd_opcode: got %h want %h", opcode, ir_m[31:26]); end
      checks++; if ({rs, rt, rd, imm} !== {ir_m[25:11], ir_m[15:0]}) begin
        errors++; $display("FAIL rnd_fields: got %h want %h", {rs, rt, rd, imm}, {ir_m[25:11], ir_m[15:0]}); end
      checks++; if (align_err !== err_m) begin errors++; $display("FAIL rnd_err: got %b want %b", align_err, err_m); end
    end
  endtask

  task automatic test_readback();
    for (int i = 0; i < MW; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 0, 32'(i * 4), 0);
      checks++; if (mdr !== mem_m[i]) begin errors++; $display("FAIL readback[%0d]: got %h want %h", i, mdr, mem_m[i]); end
    end
  endtask

  initial begin
`ifdef MC_ALIGN_CHECK_EN
    align_on = 1'b1;
`else
    align_on = 1'b0;
`endif
    IorD = 0; MemRead = 0; MemWrite = 0; IRWrite = 0; PCWrite_F = 0;
    PCSource = 2'd3; alu_result = '0; alu_out = '0; wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    preload();
    test_reset();
    test_fetch();
    test_mdr_hold();
    test_write_wrap();
    test_jump();
    test_align();
    test_random();
    test_readback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
